// File: rtl/key_led_ctrl.sv
// Multi-channel key-to-LED controller: sync, tick-based debounce, per-channel follow/toggle/blink/off LED drive.
// Latency: key edge to stable is 2 sync cycles + up to DB_N*DIV cycles; stable to led/press is 1 cycle.
// Backpressure: none; free-running single-clock datapath, outputs are always valid.
module key_led_ctrl #(
    parameter int CH          = 4,
    parameter int DIV         = 5000,
    parameter int DIV_W       = 17,
    parameter int DB_N        = 4,
    parameter int BLINK_TICKS = 50
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CH-1:0]     key,
    input  logic [2*CH-1:0]   mode,
    output logic [CH-1:0]     led,
    output logic [CH-1:0]     press,
    output logic              tick
);

    localparam int DBW = $clog2(DB_N + 1);
    localparam int BW  = $clog2(BLINK_TICKS + 1);

    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV - 1);
    localparam logic [DBW-1:0]   DB_MAX  = DBW'(DB_N - 1);
    localparam logic [BW-1:0]    B_MAX   = BW'(BLINK_TICKS - 1);

    logic [DIV_W-1:0] r_cnt;
    logic [CH-1:0]    r_sync1;
    logic [CH-1:0]    r_sync2;
    logic [CH-1:0]    r_stable;
    logic [CH-1:0]    r_stable_d;
    logic [DBW-1:0]   r_db_cnt [CH];
    logic [CH-1:0]    r_press;
    logic [CH-1:0]    r_tog;
    logic [BW-1:0]    r_bcnt;
    logic             r_blink;
    logic [CH-1:0]    r_led;

    logic             w_tick;
    logic [CH-1:0]    w_tog_nxt;
    logic [CH-1:0]    w_led_nxt;

    // Tick is decoded from the counter so its period is exactly DIV cycles.
    assign w_tick    = (r_cnt == CNT_MAX);
    // A toggle-mode LED reflects a press in the same edge that flips the toggle state.
    assign w_tog_nxt = r_tog ^ r_press;

    assign tick  = w_tick;
    assign press = r_press;
    assign led   = r_led;

    // Prescaler: free-running 0..DIV-1 counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchroniser; resets to released so no false press after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a change only after DB_N consecutive disagreeing ticks.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stable <= '1;
            for (int i = 0; i < CH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < CH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Press pulse one cycle after stable falls; toggle state follows the pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stable_d <= '1;
            r_press    <= '0;
            r_tog      <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
            r_tog      <= w_tog_nxt;
        end
    end

    // Shared blink phase: inverts every BLINK_TICKS ticks.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == B_MAX) begin
                r_bcnt  <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    // Per-channel LED mode select.
    always_comb begin
        w_led_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            case (mode[2*i +: 2])
                2'b00:   w_led_nxt[i] = ~r_stable[i];
                2'b01:   w_led_nxt[i] = w_tog_nxt[i];
                2'b10:   w_led_nxt[i] = ~r_stable[i] & r_blink;
                default: w_led_nxt[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with DIV=4, DB_N=3, BLINK_TICKS=2, CH=4.
// Outputs are sampled on the falling edge; expected values are hand-derived constants.
// Press pulses are counted by a monitor so pulse width and count can be checked.
module tb_key_led_ctrl;

    localparam int CH = 4;

    logic            sys_clk;
    logic            sys_rst_n;
    logic [CH-1:0]   key;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   led;
    logic [CH-1:0]   press;
    logic            tick;

    int checks = 0;
    int errors = 0;

    int  press_hi   [CH];
    int  press_rise [CH];
    logic [CH-1:0] press_prev;
    logic          led1_seen;

    key_led_ctrl #(
        .CH(CH), .DIV(4), .DIV_W(3), .DB_N(3), .BLINK_TICKS(2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key      (key),
        .mode     (mode),
        .led      (led),
        .press    (press),
        .tick     (tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            press_hi[i]   = 0;
            press_rise[i] = 0;
        end
        press_prev = '0;
        led1_seen  = 1'b0;
    end

    always @(negedge sys_clk) begin
        for (int i = 0; i < CH; i++) begin
            if (press[i] === 1'b1) begin
                press_hi[i]++;
                if (!press_prev[i]) press_rise[i]++;
            end
        end
        press_prev = press;
        if (led[1] === 1'b1) led1_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_tick, bad_out, n_tick, n;
        logic prev;

        // Reset state
        sys_rst_n = 1'b0;
        key       = '1;
        mode      = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_led",   32'(led),   32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_tick",  32'(tick),  32'h0);
        sys_rst_n = 1'b1;

        // Idle: tick after edges 3,7,11,..., no LED or press activity
        bad_tick = 0; bad_out = 0; n_tick = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge sys_clk);
            if (tick !== ((k % 4) == 3)) bad_tick++;
            if (tick === 1'b1) n_tick++;
            if (led !== '0 || press !== '0) bad_out++;
        end
        check("idle_tick_phase", 32'(bad_tick), 32'd0);
        check("idle_tick_count", 32'(n_tick),   32'd25);
        check("idle_outputs",    32'(bad_out),  32'd0);

        // Ch0 follow: press then release
        key[0] = 1'b0;
        n = 0;
        while (led[0] !== 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("ch0_on_latency_ok", 32'(n >= 12 && n <= 15), 32'd1);
        repeat (4) @(negedge sys_clk);
        check("ch0_press_cycles", 32'(press_hi[0]),   32'd1);
        check("ch0_press_pulses", 32'(press_rise[0]), 32'd1);
        key[0] = 1'b1;
        n = 0;
        while (led[0] !== 1'b0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("ch0_off_latency_ok", 32'(n >= 12 && n <= 15), 32'd1);
        repeat (4) @(negedge sys_clk);
        check("ch0_no_release_press", 32'(press_hi[0]), 32'd1);

        // Ch1 bounce: two-tick lows never accepted
        led1_seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            key[1] = 1'b0;
            repeat (8) @(negedge sys_clk);
            key[1] = 1'b1;
            repeat (8) @(negedge sys_clk);
        end
        repeat (16) @(negedge sys_clk);
        check("ch1_bounce_led",   32'(led1_seen),    32'd0);
        check("ch1_bounce_press", 32'(press_hi[1]),  32'd0);

        // Ch2 toggle: 0 -> 1 -> 0 -> 1, then off and back
        mode[5:4] = 2'b01;
        @(negedge sys_clk);
        check("ch2_tog_init", 32'(led[2]), 32'd0);
        for (int p = 1; p <= 3; p++) begin
            key[2] = 1'b0;
            repeat (20) @(negedge sys_clk);
            key[2] = 1'b1;
            repeat (20) @(negedge sys_clk);
            check($sformatf("ch2_tog_led_%0d", p), 32'(led[2]), 32'(p % 2));
            check($sformatf("ch2_tog_press_%0d", p), 32'(press_rise[2]), 32'(p));
        end
        check("ch2_press_width", 32'(press_hi[2]), 32'd3);
        mode[5:4] = 2'b11;
        @(negedge sys_clk);
        check("ch2_mode_off", 32'(led[2]), 32'd0);
        mode[5:4] = 2'b01;
        @(negedge sys_clk);
        check("ch2_mode_back", 32'(led[2]), 32'd1);

        // Ch3 blink while held: half period 2 ticks = 8 cycles
        mode[7:6] = 2'b10;
        key[3]    = 1'b0;
        repeat (20) @(negedge sys_clk);
        prev = led[3];
        n = 0;
        while (led[3] === prev && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("ch3_blink_changes", 32'(n < 20), 32'd1);
        for (int h = 0; h < 2; h++) begin
            prev = led[3];
            n = 0;
            while (led[3] === prev && n < 20) begin
                @(negedge sys_clk);
                n++;
            end
            check($sformatf("ch3_blink_half_%0d", h), 32'(n), 32'd8);
        end
        key[3] = 1'b1;
        repeat (16) @(negedge sys_clk);
        check("ch3_released_off", 32'(led[3]), 32'd0);
        repeat (10) @(negedge sys_clk);
        check("ch3_stays_off",  32'(led[3]),        32'd0);
        check("ch3_press_once", 32'(press_hi[3]),   32'd1);

        // Async reset mid-debounce with tog[2]=1
        check("pre_rst_tog_led", 32'(led[2]), 32'd1);
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            @(negedge sys_clk);
            n++;
        end
        key[0] = 1'b0;
        repeat (9) @(negedge sys_clk);
        check("pre_rst_ch0_pending", 32'(led[0]), 32'd0);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_led",   32'(led),   32'h0);
        check("mid_rst_press", 32'(press), 32'h0);
        check("mid_rst_tick",  32'(tick),  32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("post_rst_tog_cleared", 32'(led[2]), 32'd0);
        n = 1;
        while (led[0] !== 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("post_rst_full_debounce", 32'(n), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
